digit_combiner_4: RTL and testbench

- Sequential BCD-to-binary converter: takes four decimal digits (thousands, hundreds, tens, ones) and produces their binary value.
- Converts on a start/valid handshake using an iterative multiply-by-10 accumulate, most significant digit first.
- Sits between digit-entry logic (buttons, switches, UART digit capture) and the binary datapath that consumes set-points and counts.

---
 rtl/digit_pkg.sv | 29 ++
 rtl/bcd_mac_step.sv | 25 ++
 rtl/digit_combiner_4.sv | 158 +++++++++++++++
 tb/tb_digit_combiner_4.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// -----------------------------------------------------------------------------
// digit_pkg
// Shared constants, state encoding and arithmetic helpers for the four-digit
// BCD-to-binary converter (digit_combiner_4) and its MAC step (bcd_mac_step).
// -----------------------------------------------------------------------------
package digit_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int ACC_W      = 14;
  localparam int IDX_W      = 2;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Multiply by ten using two shifts and one add so no multiplier is inferred.
  function automatic logic [ACC_W-1:0] mul10(input logic [ACC_W-1:0] value);
    mul10 = (value << 3) + (value << 1);
  endfunction

  // A BCD digit is only legal in the range 0..9.
  function automatic logic bcd_invalid(input logic [3:0] digit);
    bcd_invalid = (digit > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// -----------------------------------------------------------------------------
// bcd_mac_step
// One combinational step of the decimal accumulate: acc_out = acc_in*10 + digit.
// Ports:
//   acc_in        [13:0] running accumulator
//   digit         [3:0]  BCD digit being folded in
//   acc_out       [13:0] updated accumulator
//   digit_invalid        digit is outside 0..9
// -----------------------------------------------------------------------------
module bcd_mac_step
  import digit_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_out,
  output logic             digit_invalid
);

  // Accumulate step and digit legality check.
  always_comb begin
    acc_out       = mul10(acc_in) + {{(ACC_W-4){1'b0}}, digit};
    digit_invalid = bcd_invalid(digit);
  end

endmodule

// File: rtl/digit_combiner_4.sv
// -----------------------------------------------------------------------------
// digit_combiner_4
// Sequential BCD-to-binary converter for four decimal digits. A start request
// in IDLE captures the digits; four ACC cycles fold them in most significant
// first; a single DONE cycle presents the registered result with o_valid.
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   i_start        conversion request, sampled only in IDLE
//   i_digit_1      ones digit (BCD)
//   i_digit_10     tens digit (BCD)
//   i_digit_100    hundreds digit (BCD)
//   i_digit_1000   thousands digit (BCD)
//   o_value        binary result, held until the next o_valid
//   o_valid        one-cycle result strobe
//   o_busy         conversion in progress (ACC and DONE)
//   o_error        a captured digit was greater than 9
//   o_overflow     result did not fit in DATAWIDTH bits
// -----------------------------------------------------------------------------
module digit_combiner_4
  import digit_pkg::*;
#(
  parameter int DATAWIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [3:0]           i_digit_1,
  input  logic [3:0]           i_digit_10,
  input  logic [3:0]           i_digit_100,
  input  logic [3:0]           i_digit_1000,
  output logic [DATAWIDTH-1:0] o_value,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_error,
  output logic                 o_overflow
);

  // Largest representable output, expressed at accumulator width.
  localparam logic [ACC_W-1:0] VALUE_MAX = ACC_W'((32'd1 << DATAWIDTH) - 32'd1);

  state_e               state_r;
  logic [ACC_W-1:0]     acc_r;
  logic [IDX_W-1:0]     idx_r;
  logic [3:0]           digits_r [NUM_DIGITS];
  logic                 err_r;

  logic [DATAWIDTH-1:0] value_r;
  logic                 valid_r;
  logic                 busy_r;
  logic                 error_r;
  logic                 overflow_r;

  logic [ACC_W-1:0]     acc_next_s;
  logic                 digit_invalid_s;
  logic                 err_next_s;
  logic [DATAWIDTH-1:0] final_value_s;
  logic                 final_ovf_s;

  bcd_mac_step u_mac (
    .acc_in        (acc_r),
    .digit         (digits_r[idx_r]),
    .acc_out       (acc_next_s),
    .digit_invalid (digit_invalid_s)
  );

  // Sticky error including the digit consumed this cycle.
  always_comb begin
    err_next_s = err_r | digit_invalid_s;
  end

  // Final result shaping: error forces zero, otherwise saturate on overflow.
  always_comb begin
    final_value_s = '0;
    final_ovf_s   = 1'b0;
    if (err_next_s) begin
      final_value_s = '0;
      final_ovf_s   = 1'b0;
    end else if (acc_next_s > VALUE_MAX) begin
      final_value_s = {DATAWIDTH{1'b1}};
      final_ovf_s   = 1'b1;
    end else begin
      final_value_s = acc_next_s[DATAWIDTH-1:0];
      final_ovf_s   = 1'b0;
    end
  end

  // Control FSM, digit capture, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      acc_r      <= '0;
      idx_r      <= '0;
      err_r      <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digits_r[i] <= 4'd0;
      end
      value_r    <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (i_start) begin
            // Index 3 holds thousands so the countdown runs MSD first.
            digits_r[3] <= i_digit_1000;
            digits_r[2] <= i_digit_100;
            digits_r[1] <= i_digit_10;
            digits_r[0] <= i_digit_1;
            acc_r       <= '0;
            err_r       <= 1'b0;
            idx_r       <= 2'd3;
            busy_r      <= 1'b1;
            state_r     <= ACC;
          end else begin
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        ACC: begin
          acc_r <= acc_next_s;
          err_r <= err_next_s;
          idx_r <= idx_r - 2'd1;
          if (idx_r == 2'd0) begin
            value_r    <= final_value_s;
            error_r    <= err_next_s;
            overflow_r <= final_ovf_s;
            valid_r    <= 1'b1;
            state_r    <= DONE;
          end else begin
            valid_r    <= 1'b0;
            state_r    <= ACC;
          end
        end
        DONE: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_value    = value_r;
  assign o_valid    = valid_r;
  assign o_busy     = busy_r;
  assign o_error    = error_r;
  assign o_overflow = overflow_r;

endmodule

// File: tb/tb_digit_combiner_4.sv
// -----------------------------------------------------------------------------
// tb_digit_combiner_4
// Drives a 14-bit and an 8-bit converter from the same inputs and compares
// both against decimal arithmetic computed directly from the digits.
// -----------------------------------------------------------------------------
module tb_digit_combiner_4;

  logic        clk;
  logic        reset_n;
  logic        i_start;
  logic [3:0]  i_digit_1;
  logic [3:0]  i_digit_10;
  logic [3:0]  i_digit_100;
  logic [3:0]  i_digit_1000;

  logic [13:0] v14;
  logic        valid14, busy14, err14, ovf14;
  logic [7:0]  v8;
  logic        valid8, busy8, err8, ovf8;

  int errors = 0;
  int checks = 0;

  digit_combiner_4 #(.DATAWIDTH(14)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_digit_1    (i_digit_1),
    .i_digit_10   (i_digit_10),
    .i_digit_100  (i_digit_100),
    .i_digit_1000 (i_digit_1000),
    .o_value      (v14),
    .o_valid      (valid14),
    .o_busy       (busy14),
    .o_error      (err14),
    .o_overflow   (ovf14)
  );

  digit_combiner_4 #(.DATAWIDTH(8)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_digit_1    (i_digit_1),
    .i_digit_10   (i_digit_10),
    .i_digit_100  (i_digit_100),
    .i_digit_1000 (i_digit_1000),
    .o_value      (v8),
    .o_valid      (valid8),
    .o_busy       (busy8),
    .o_error      (err8),
    .o_overflow   (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) == 0) rand_digit = 4'($urandom_range(10, 15));
    else rand_digit = 4'($urandom_range(0, 9));
  endfunction

  // One conversion; optionally disturbs digits and re-pulses start mid-flight.
  task automatic convert(input logic [3:0] th, input logic [3:0] hu,
                         input logic [3:0] te, input logic [3:0] on,
                         input bit disturb, input string tag);
    int  val, e14, e8;
    bit  bad, o8;
    int  lat, busy_cnt, valid_cnt;
    bad = (th > 9) || (hu > 9) || (te > 9) || (on > 9);
    val = int'(th) * 1000 + int'(hu) * 100 + int'(te) * 10 + int'(on);
    e14 = bad ? 0 : val;
    o8  = !bad && (val > 255);
    e8  = bad ? 0 : (o8 ? 255 : val);

    @(negedge clk);
    i_digit_1000 = th; i_digit_100 = hu; i_digit_10 = te; i_digit_1 = on;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check({tag, "_busy_at_accept"}, 32'(busy14), 32'd1);
    busy_cnt = busy14 ? 1 : 0;
    valid_cnt = 0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (disturb && c <= 2) begin
        i_digit_1000 = 4'($urandom_range(0, 9));
        i_digit_100  = 4'($urandom_range(0, 9));
        i_digit_10   = 4'($urandom_range(0, 9));
        i_digit_1    = 4'($urandom_range(0, 9));
        i_start      = 1'b1;
      end else begin
        i_start      = 1'b0;
      end
      @(negedge clk);
      if (busy14) busy_cnt++;
      if (valid14) begin
        valid_cnt++;
        if (lat == 0) begin
          lat = c;
          check({tag, "_value14"}, 32'(v14), 32'(e14));
          check({tag, "_error14"}, 32'(err14), 32'(bad));
          check({tag, "_ovf14"}, 32'(ovf14), 32'd0);
          check({tag, "_valid8"}, 32'(valid8), 32'd1);
          check({tag, "_value8"}, 32'(v8), 32'(e8));
          check({tag, "_error8"}, 32'(err8), 32'(bad));
          check({tag, "_ovf8"}, 32'(ovf8), 32'(o8));
        end
      end
    end
    i_start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_valid_count"}, 32'(valid_cnt), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
    check({tag, "_held14"}, 32'(v14), 32'(e14));
    check({tag, "_held8"}, 32'(v8), 32'(e8));
  endtask

  initial begin
    int vcnt;
    reset_n = 1'b0;
    i_start = 1'b0;
    i_digit_1 = 4'd0; i_digit_10 = 4'd0; i_digit_100 = 4'd0; i_digit_1000 = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_value", 32'(v14), 32'd0);
    check("reset_valid", 32'(valid14), 32'd0);
    check("reset_busy", 32'(busy14), 32'd0);
    check("reset_error", 32'(err14), 32'd0);
    check("reset_ovf", 32'(ovf14), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", 32'(busy14), 32'd0);

    convert(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "d1234");
    convert(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, "d9999");
    convert(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, "d0000");
    convert(4'd0, 4'd0, 4'hA, 4'd5, 1'b0, "d00A5");
    convert(4'd0, 4'd2, 4'd5, 4'd5, 1'b0, "d0255");
    convert(4'd0, 4'd2, 4'd5, 4'd6, 1'b0, "d0256");
    convert(4'hF, 4'd0, 4'd0, 4'd0, 1'b0, "dF000");
    convert(4'd5, 4'd6, 4'd7, 4'd8, 1'b1, "disturb5678");

    for (int n = 0; n < 20; n++) begin
      convert(rand_digit(), rand_digit(), rand_digit(), rand_digit(), 1'b0, "rand");
    end

    // Reset during the second ACC cycle.
    convert(4'd3, 4'd1, 4'd4, 4'd1, 1'b0, "d3141");
    @(negedge clk);
    i_digit_1000 = 4'd1; i_digit_100 = 4'd2; i_digit_10 = 4'd3; i_digit_1 = 4'd4;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_value14", 32'(v14), 32'd0);
    check("midreset_value8", 32'(v8), 32'd0);
    check("midreset_valid", 32'(valid14), 32'd0);
    check("midreset_busy", 32'(busy14), 32'd0);
    check("midreset_error", 32'(err14), 32'd0);
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid14 || valid8) vcnt++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (valid14 || valid8) vcnt++;
    end
    check("midreset_no_valid", 32'(vcnt), 32'd0);
    convert(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, "after_reset_0042");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
